// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package wb_arb_pkg;

    localparam int unsigned DEF_XLEN       = 32;
    localparam int unsigned DEF_REG_ADDR_W = 5;
    localparam int unsigned X0_IDX         = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry parking buffer for a multi-cycle result awaiting the write port.
module wb_hold_buf #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  drain,
    input  logic                  discard,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_data,
    output logic                  hold_valid,
    output logic [REG_ADDR_W-1:0] hold_rd,
    output logic [XLEN-1:0]       hold_data
);

    // Load has precedence; it never coincides with drain/discard since loads only happen when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
        end else if (load) begin
            hold_valid <= 1'b1;
            hold_rd    <= in_rd;
            hold_data  <= in_data;
        end else if (drain || discard) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the reg_file write port between the core writeback path and parked multi-cycle results.
module reg_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT   = 4,
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_we,
    input  logic [REG_ADDR_W-1:0] core_rd,
    input  logic [XLEN-1:0]       core_data,
    output logic                  core_stall,
    input  logic                  mc_valid,
    output logic                  mc_ready,
    input  logic [REG_ADDR_W-1:0] mc_rd,
    input  logic [XLEN-1:0]       mc_data,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] rd_sel,
    output logic [XLEN-1:0]       wb_data,
    output logic                  pend_valid,
    output logic [REG_ADDR_W-1:0] pend_rd
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  core_eff;
    logic                  load;
    logic                  drain;
    logic                  discard;
    logic                  hold_valid;
    logic [REG_ADDR_W-1:0] hold_rd;
    logic [XLEN-1:0]       hold_data;

    // A write to x0 is architecturally a no-op, so it never claims the port.
    assign core_eff   = core_we && (core_rd != REG_ADDR_W'(X0_IDX));
    assign mc_ready   = !hold_valid;
    assign load       = mc_valid && mc_ready && (mc_rd != REG_ADDR_W'(X0_IDX));
    assign pend_valid = hold_valid;
    assign pend_rd    = hold_rd;
    assign cnt_inc    = wait_cnt_q + CNT_W'(1);

    wb_hold_buf #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .drain      (drain),
        .discard    (discard),
        .in_rd      (mc_rd),
        .in_data    (mc_data),
        .hold_valid (hold_valid),
        .hold_rd    (hold_rd),
        .hold_data  (hold_data)
    );

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state, starvation counting and the same-cycle port mux.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        reg_write  = 1'b0;
        rd_sel     = core_rd;
        wb_data    = core_data;
        core_stall = 1'b0;
        drain      = 1'b0;
        discard    = 1'b0;

        if (hold_valid && ((state_q == FORCE) || !core_eff)) begin
            drain     = 1'b1;
            reg_write = 1'b1;
            rd_sel    = hold_rd;
            wb_data   = hold_data;
        end else if (core_eff) begin
            reg_write = 1'b1;
        end

        // Core result to the same register is newer; the parked value is stale.
        if (hold_valid && (state_q == WAIT) && core_eff && (core_rd == hold_rd)) begin
            discard = 1'b1;
        end

        if ((state_q == FORCE) && core_we) begin
            core_stall = 1'b1;
        end

        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (load) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!hold_valid || drain || discard) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (core_eff) begin
                    wait_cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MAX_WAIT)) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase

        // Reset must silence the port immediately, even with the core still requesting.
        if (!reset) begin
            reg_write  = 1'b0;
            core_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with hand-computed expectations.
module tb_reg_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_data;
    logic        core_stall;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        reg_write;
    logic [4:0]  rd_sel;
    logic [31:0] wb_data;
    logic        pend_valid;
    logic [4:0]  pend_rd;

    int n_checks;
    int n_pass;

    reg_wb_arbiter #(
        .MAX_WAIT   (4),
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_we    (core_we),
        .core_rd    (core_rd),
        .core_data  (core_data),
        .core_stall (core_stall),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_rd      (mc_rd),
        .mc_data    (mc_data),
        .reg_write  (reg_write),
        .rd_sel     (rd_sel),
        .wb_data    (wb_data),
        .pend_valid (pend_valid),
        .pend_rd    (pend_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        core_we   = 1'b0;
        core_rd   = '0;
        core_data = '0;
        mc_valid  = 1'b0;
        mc_rd     = '0;
        mc_data   = '0;

        #12;
        check("rst_pend_valid", 32'(pend_valid), 32'd0);
        check("rst_mc_ready",   32'(mc_ready),   32'd1);
        check("rst_reg_write",  32'(reg_write),  32'd0);
        check("rst_core_stall", 32'(core_stall), 32'd0);
        reset = 1'b1;

        // 1: core write goes straight through
        core_we = 1'b1; core_rd = 5'd7; core_data = 32'h1234_5678;
        #2;
        check("t1_reg_write", 32'(reg_write), 32'd1);
        check("t1_rd_sel",    32'(rd_sel),    32'd7);
        check("t1_wb_data",   wb_data,        32'h1234_5678);
        check("t1_mc_ready",  32'(mc_ready),  32'd1);
        check("t1_stall",     32'(core_stall),32'd0);
        cyc();

        // 2: park and drain on an idle port
        core_we = 1'b0; mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hDEAD_BEEF;
        #2;
        check("t2_acc_reg_write", 32'(reg_write), 32'd0);
        cyc();
        mc_valid = 1'b0;
        #2;
        check("t2_pend_valid", 32'(pend_valid), 32'd1);
        check("t2_pend_rd",    32'(pend_rd),    32'd10);
        check("t2_mc_ready",   32'(mc_ready),   32'd0);
        check("t2_reg_write",  32'(reg_write),  32'd1);
        check("t2_rd_sel",     32'(rd_sel),     32'd10);
        check("t2_wb_data",    wb_data,         32'hDEAD_BEEF);
        cyc();
        #2;
        check("t2_after_pend", 32'(pend_valid), 32'd0);
        check("t2_after_rdy",  32'(mc_ready),   32'd1);
        check("t2_after_we",   32'(reg_write),  32'd0);
        cyc();

        // 3: starvation forces the parked result after MAX_WAIT blocked cycles
        mc_valid = 1'b1; mc_rd = 5'd15; mc_data = 32'hCAFE_BABE;
        #2;
        cyc();
        mc_valid = 1'b0;
        for (int r = 3; r <= 6; r++) begin
            core_we = 1'b1; core_rd = 5'(r); core_data = 32'(r + 100);
            #2;
            check("t3_core_we",   32'(reg_write),  32'd1);
            check("t3_core_rd",   32'(rd_sel),     32'(r));
            check("t3_core_data", wb_data,         32'(r + 100));
            check("t3_no_stall",  32'(core_stall), 32'd0);
            check("t3_pending",   32'(pend_valid), 32'd1);
            cyc();
        end
        core_rd = 5'd7; core_data = 32'd107;
        #2;
        check("t3_force_stall", 32'(core_stall), 32'd1);
        check("t3_force_we",    32'(reg_write),  32'd1);
        check("t3_force_rd",    32'(rd_sel),     32'd15);
        check("t3_force_data",  wb_data,         32'hCAFE_BABE);
        cyc();
        #2;
        check("t3_rd7_stall", 32'(core_stall), 32'd0);
        check("t3_rd7_sel",   32'(rd_sel),     32'd7);
        check("t3_rd7_pend",  32'(pend_valid), 32'd0);
        cyc();
        core_rd = 5'd8; core_data = 32'd108;
        #2;
        check("t3_rd8_sel",   32'(rd_sel),     32'd8);
        check("t3_rd8_stall", 32'(core_stall), 32'd0);
        cyc();
        core_we = 1'b0;

        // 4a: multi-cycle result to x0 is accepted and dropped
        mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'hFFFF_FFFF;
        #2;
        check("t4a_ready", 32'(mc_ready), 32'd1);
        cyc();
        mc_valid = 1'b0;
        #2;
        check("t4a_pend",  32'(pend_valid), 32'd0);
        check("t4a_we",    32'(reg_write),  32'd0);
        check("t4a_ready2",32'(mc_ready),   32'd1);
        cyc();

        // 4b: core write to x0 leaves the port free for the parked result
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h1111_1111;
        #2;
        cyc();
        mc_valid = 1'b0; core_we = 1'b1; core_rd = 5'd0; core_data = 32'd55;
        #2;
        check("t4b_we",    32'(reg_write),  32'd1);
        check("t4b_rd",    32'(rd_sel),     32'd9);
        check("t4b_data",  wb_data,         32'h1111_1111);
        check("t4b_stall", 32'(core_stall), 32'd0);
        cyc();
        core_we = 1'b0;
        #2;
        check("t4b_pend", 32'(pend_valid), 32'd0);
        cyc();

        // 5: core write to the parked register supersedes it
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h2222_2222;
        #2;
        cyc();
        mc_valid = 1'b0; core_we = 1'b1; core_rd = 5'd9; core_data = 32'h0000_0009;
        #2;
        check("t5_we",   32'(reg_write), 32'd1);
        check("t5_rd",   32'(rd_sel),    32'd9);
        check("t5_data", wb_data,        32'h0000_0009);
        cyc();
        core_we = 1'b0;
        #2;
        check("t5_pend",  32'(pend_valid), 32'd0);
        check("t5_no_we", 32'(reg_write),  32'd0);
        cyc();
        #2;
        check("t5_no_we2", 32'(reg_write), 32'd0);
        cyc();

        // 6: asynchronous reset while a result is parked and partly starved
        mc_valid = 1'b1; mc_rd = 5'd12; mc_data = 32'h0C0C_0C0C;
        #2;
        cyc();
        mc_valid = 1'b0; core_we = 1'b1; core_rd = 5'd1; core_data = 32'd1;
        cyc();
        core_rd = 5'd2; core_data = 32'd2;
        cyc();
        core_rd = 5'd3; core_data = 32'd3;
        #2;
        check("t6_pre_pend", 32'(pend_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_pend",  32'(pend_valid), 32'd0);
        check("t6_rst_we",    32'(reg_write),  32'd0);
        check("t6_rst_ready", 32'(mc_ready),   32'd1);
        check("t6_rst_stall", 32'(core_stall), 32'd0);
        core_we = 1'b0;
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #2;
            check("t6_post_we",   32'(reg_write),  32'd0);
            check("t6_post_pend", 32'(pend_valid), 32'd0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Shares the single write port of reg_file between the core writeback path and a multi-cycle execution unit (mul/div, load). The core path has priority and adds zero latency. Multi-cycle results are parked in a one-entry holding buffer and drained when the port is free. A starvation counter stalls the core once so a parked result is always written within a bounded time. The block also exposes the parked destination so decode can detect read-after-write hazards.

Parameters:
MAX_WAIT, 4, max consecutive blocked cycles before a parked result forces the port (must be >= 1)
XLEN, 32, data width
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
core_we  input  1  core writeback request
core_rd  input  REG_ADDR_W  core destination register
core_data  input  XLEN  core writeback data
core_stall  output  1  core writeback was not performed; core holds its values
mc_valid  input  1  multi-cycle result valid
mc_ready  output  1  holding buffer can accept a result
mc_rd  input  REG_ADDR_W  multi-cycle destination register
mc_data  input  XLEN  multi-cycle result
reg_write  output  1  write enable to reg_file
rd_sel  output  REG_ADDR_W  write index to reg_file
wb_data  output  XLEN  write data to reg_file
pend_valid  output  1  holding buffer occupied
pend_rd  output  REG_ADDR_W  destination register of the parked result

Behaviour:
- Definition: core_eff = core_we && core_rd != 0. A core write to x0 never occupies the port.
- Reset (reset low, asynchronous):
  - hold_valid=0, state=IDLE, wait_cnt=0.
  - Outputs forced to reg_write=0, core_stall=0, pend_valid=0, mc_ready=1.
  - A parked result is lost.
- Holding buffer:
  - mc_ready = !hold_valid.
  - Accept on mc_valid && mc_ready at the clock edge.
  - If mc_rd == 0, the result is accepted and dropped; hold is not set.
- pend_valid = hold_valid; pend_rd = hold_rd.
- Port mux (combinational, same cycle):
  - If hold_valid && (state==FORCE || !core_eff): write the parked result (reg_write=1, rd_sel=hold_rd, wb_data=hold_data). hold_valid clears at the edge.
  - Otherwise, if core_eff: write the core result.
  - Otherwise: reg_write=0, and rd_sel/wb_data pass the core values through.
- core_stall = (state==FORCE) && core_we. The core write is suppressed in that cycle.
- States and transitions:
  - IDLE: goes to WAIT on an accepted result with mc_rd != 0.
  - WAIT:
    - If the buffer drains this cycle: go to IDLE, wait_cnt=0.
    - If blocked by core_eff: wait_cnt+1. If wait_cnt+1 == MAX_WAIT, go to FORCE.
  - FORCE: the drain is guaranteed. Go to IDLE next cycle, wait_cnt=0.
- WAW rule: in WAIT, core_eff with core_rd == hold_rd means the core result is the newer value.
  - The core writes.
  - The hold entry is discarded at the edge.
  - Go to IDLE, wait_cnt=0.
- Latency:
  - Core path: 0 cycles.
  - Parked result: written at the earliest edge after acceptance where the port is free.
  - Worst case: written in cycle accept+MAX_WAIT+1.
- Accept and drain can never occur in the same cycle, because mc_ready is low while the buffer is full.
- wait_cnt width is $clog2(MAX_WAIT+1); it saturates by construction.

Decomposition:
- Package wb_arb_pkg:
  - arb_state_t enum {IDLE, WAIT, FORCE}
  - XLEN, REG_ADDR_W defaults
  - X0_IDX = 0
- Sub-module wb_hold_buf: one-entry valid/rd/data register with accept, drain and discard inputs, async active-low reset.
- FSM, counter and port mux stay in reg_wb_arbiter.

Test Plan:
1. Release reset; core_we=1, core_rd=7, core_data=12345678 -> same cycle reg_write=1, rd_sel=7, wb_data=12345678, mc_ready=1, core_stall=0.
2. Core idle; mc_valid=1, mc_rd=10, mc_data=DEADBEEF -> next cycle pend_valid=1, pend_rd=10, mc_ready=0, reg_write=1, rd_sel=10, wb_data=DEADBEEF. Following cycle pend_valid=0, mc_ready=1.
3. MAX_WAIT=4; park rd=15 data CAFEBABE while the core writes rd=3..8 on consecutive cycles:
   - Core writes rd 3..6 normally.
   - Next cycle: core_stall=1, rd_sel=15, wb_data=CAFEBABE.
   - Core then writes rd 7 and 8.
4. x0 filtering:
   - mc_rd=0, mc_data=FFFFFFFF -> accepted, pend_valid stays 0, no write.
   - core_we=1, core_rd=0 while rd=9 is parked -> parked rd=9 drains that cycle.
5. WAW: rd=9 parked; core writes rd=9 data 00000009 -> reg_write rd_sel=9 wb_data=00000009. pend_valid=0 next cycle; no later write to x9.
6. Reset mid-operation: rd=12 parked, wait_cnt=2, then reset asserted between edges -> immediately pend_valid=0, reg_write=0, mc_ready=1. After release, no write to x12 occurs.
